// File: rtl/excp_commit.sv
// Commit-stage exception/ERTN sequencer: encodes an accepted instruction's exception,
// hands it to the CSR file, retries on failure and drives flush/redirect on a taken jump.
module excp_commit #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [5:0]  in_flags,
  input  logic [31:0] in_vaddr,
  input  logic        have_intrpt,
  output logic [81:0] csr_bus,
  input  logic        excp_jump,
  input  logic [31:0] excp_pc,
  input  logic        jump_excp_fail,
  output logic        csr_wen_block,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RETRY = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  logic [1:0]  state_q, state_d;
  logic        pend_q, pend_d;
  logic        retried_q, retried_d;
  logic [81:0] payload_q, payload_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rv_q, rv_d;
  logic [31:0] rpc_q, rpc_d;

  logic        pend_now;
  logic        accept;
  logic [81:0] payload_new;

  assign pend_now = pend_q | have_intrpt;
  assign accept   = in_valid & (state_q == IDLE);

  // Payload layout: {is_etrn, in_excp, ecode, subecode, era, use_badv, bad_vaddr}
  always_comb begin
    payload_new = '0;
    if (pend_now) begin
      payload_new = {1'b0, 1'b1, 6'h00, 9'h0, in_pc, 1'b0, 32'h0};
    end else if (in_flags[0]) begin
      payload_new = {1'b0, 1'b1, 6'h08, 9'h0, in_pc, 1'b1, in_pc};
    end else if (in_flags[1]) begin
      payload_new = {1'b0, 1'b1, 6'h0D, 9'h0, in_pc, 1'b0, 32'h0};
    end else if (in_flags[2]) begin
      payload_new = {1'b0, 1'b1, 6'h0B, 9'h0, in_pc, 1'b0, 32'h0};
    end else if (in_flags[3]) begin
      payload_new = {1'b0, 1'b1, 6'h0C, 9'h0, in_pc, 1'b0, 32'h0};
    end else if (in_flags[4]) begin
      payload_new = {1'b0, 1'b1, 6'h09, 9'h0, in_pc, 1'b1, in_vaddr};
    end else if (in_flags[5]) begin
      payload_new = {1'b1, 1'b0, 80'h0};
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_now;
    retried_d = retried_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    rv_d      = 1'b0;
    rpc_d     = rpc_q;
    case (state_q)
      IDLE: begin
        // Clean instructions with nothing pending are consumed without leaving IDLE.
        if (accept && (pend_now || (|in_flags))) begin
          payload_d = payload_new;
          retried_d = 1'b0;
          state_d   = ISSUE;
          if (pend_now) pend_d = 1'b0;
        end
      end
      ISSUE: begin
        if (excp_jump) begin
          rpc_d     = excp_pc;
          rv_d      = 1'b1;
          cnt_d     = FLUSH_INIT;
          retried_d = 1'b0;
          state_d   = FLUSH;
        end else if (jump_excp_fail) begin
          retried_d = 1'b1;
          state_d   = RETRY;
        end else begin
          retried_d = 1'b0;
          state_d   = IDLE;
        end
      end
      RETRY: state_d = ISSUE;
      FLUSH: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      retried_q <= 1'b0;
      payload_q <= '0;
      cnt_q     <= 4'd0;
      rv_q      <= 1'b0;
      rpc_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      retried_q <= retried_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
    end
  end

  // Outputs are gated by rst so a reset cycle never presents a live request.
  assign in_ready       = (state_q == IDLE);
  assign csr_bus        = (state_q == ISSUE && !rst) ? payload_q : '0;
  assign csr_wen_block  = !rst && ((state_q == RETRY) || (state_q == ISSUE && retried_q));
  assign flush          = !rst && (state_q == FLUSH);
  assign redirect_valid = !rst && rv_q;
  assign redirect_pc    = rpc_q;

endmodule

// File: doc/excp_commit.md
EXCP_COMMIT -- requirements
Module: excp_commit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a taken exception/ertn (legal 1..15).
REQ-002 SHALL have ports, clock and reset first: clk in 1 clock; rst in 1 reset, synchronous, active-high; clock clk.
REQ-003 SHALL have in_valid in 1 commit-stage instruction valid; in_ready out 1 block can accept; in_pc in 32 instruction PC.
REQ-004 SHALL have in_flags in 6 per-instruction exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE, [5] ERTN; in_vaddr in 32 memory address for ALE.
REQ-005 SHALL have have_intrpt in 1 interrupt pending from CSR file.
REQ-006 SHALL have csr_bus out 82 packed {is_etrn, in_excp, ecode[5:0], subecode[8:0], era[31:0], use_badv, bad_vaddr[31:0]}, MSB first.
REQ-007 SHALL have excp_jump in 1, excp_pc in 32, jump_excp_fail in 1, all combinational responses from the CSR file to csr_bus.
REQ-008 SHALL have csr_wen_block out 1 suppress commit-stage CSR write; flush out 1 pipeline flush; redirect_valid out 1 one-cycle fetch redirect; redirect_pc out 32 redirect target.

Function
REQ-009 SHALL implement states IDLE, ISSUE, RETRY, FLUSH; in_ready = 1 only in IDLE.
REQ-010 SHALL accept an instruction on in_valid & in_ready; instructions with in_flags==0 and no pending interrupt SHALL cause no state change and csr_bus stays 0.
REQ-011 SHALL latch interrupt-pending sticky when have_intrpt=1 in any state; cleared when an interrupt is issued or on reset.
REQ-012 SHALL, on accept with pending interrupt, attach it to that instruction: ecode 0x00, subecode 0, era=in_pc, use_badv=0; interrupt overrides all flags including ERTN.
REQ-013 SHALL otherwise priority-encode flags ADEF > INE > SYS > BRK > ALE > ERTN.
REQ-014 SHALL encode ADEF: ecode 0x08 subcode 0, use_badv=1, bad_vaddr=in_pc; INE 0x0D; SYS 0x0B; BRK 0x0C; ALE 0x09, use_badv=1, bad_vaddr=in_vaddr; era=in_pc for all; in_excp=1, is_etrn=0.
REQ-015 SHALL encode ERTN-only as is_etrn=1, in_excp=0, all other fields 0.
REQ-016 SHALL register the payload on accept, enter ISSUE next cycle and drive csr_bus with it for exactly that one cycle; csr_bus SHALL be 0 in every other state/cycle.
REQ-017 In ISSUE, excp_jump=1: SHALL capture excp_pc into redirect_pc, assert redirect_valid for one cycle (next cycle), enter FLUSH.
REQ-018 In ISSUE, jump_excp_fail=1: SHALL enter RETRY, retain payload, assert csr_wen_block in RETRY and the following ISSUE.
REQ-019 RETRY SHALL last exactly one cycle, then return to ISSUE re-driving the identical payload.
REQ-020 In ISSUE with neither excp_jump nor jump_excp_fail: SHALL return to IDLE, no flush, no redirect.
REQ-021 FLUSH SHALL assert flush for exactly FLUSH_CYCLES cycles using a 4-bit down-counter, then return to IDLE; redirect_valid coincides with the first flush cycle.
REQ-022 SHALL ignore in_valid outside IDLE; upstream holds the instruction until in_ready.
REQ-023 have_intrpt rising during ISSUE/RETRY/FLUSH SHALL only set the sticky pending bit, attached to the next accepted instruction.

Reset
REQ-024 On rst: state IDLE, in_ready=1, csr_bus=0, csr_wen_block=0, flush=0, redirect_valid=0, redirect_pc=0, counter 0, pending bit 0.
REQ-025 rst asserted in any state SHALL abort the operation in that cycle with no further csr_bus, flush or redirect output.

Verification
REQ-026 SYS at pc 0x1C000010, excp_jump=1, excp_pc=0x1C008000 -> csr_bus ecode 0x0B era 0x1C000010 one cycle; redirect_pc 0x1C008000; flush 2 cycles.
REQ-027 Flags ADEF|ALE, pc 0x00000003, vaddr 0x00001001 -> ecode 0x08 sub 0, use_badv=1, bad_vaddr 0x00000003.
REQ-028 BRK with jump_excp_fail=1 on first ISSUE -> RETRY 1 cycle, csr_wen_block=1 two cycles, identical ecode 0x0C reissued, then flush.
REQ-029 have_intrpt pulse during FLUSH, next instr ERTN at pc 0x80 -> ecode 0x00 era 0x80, is_etrn=0, pending cleared.
REQ-030 ERTN only, excp_pc=0x1C000100 -> is_etrn=1 in_excp=0, redirect_pc 0x1C000100; FLUSH_CYCLES=1 variant -> flush 1 cycle.
REQ-031 rst during FLUSH cycle 1 -> next cycle all outputs 0, in_ready=1.
